multi_timer: RTL and testbench
==============================

MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter base_address, default 32'h4100, is the byte address of the register window and SHALL be 64-byte aligned.
REQ-002 Parameter CHANNELS, default 4, range 1..8, is the number of compare/PWM channels.
REQ-003 Parameter WIDTH, default 16, range 8..32, is the counter and compare-register width.
REQ-004 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  is an asynchronous, active-low reset.
REQ-006 data_bus_data  inout  32  is the shared data bus: written data in, read data out.
REQ-007 data_bus_addr  input  32  is the byte address of the bus access.
REQ-008 data_bus_mode  input  2  gives the access type: 2'b00 idle, 2'b01 read, 2'b10 write, 2'b11 treated as idle.
REQ-009 timer_irq  output  1  is the level interrupt request.
REQ-010 comparator_out  output  CHANNELS  carries the per-channel PWM outputs.

Function
REQ-011 Hit SHALL be data_bus_addr[31:6] == base_address[31:6]; offset SHALL be data_bus_addr[5:0]; word accesses only.
REQ-012 The register map SHALL be:
- 0x00 CTRL: bit0 EN, bit1 ONESHOT, bits[15:8] PRESCALE.
- 0x04 COUNT.
- 0x08 RELOAD.
- 0x0C STATUS: bit c = compare flag of channel c; bit 8 = overflow flag; write-1-to-clear.
- 0x10 IRQEN: same bit layout as STATUS.
- 0x20+4*c CMP[c].
REQ-013 Read with hit SHALL drive data_bus_data combinationally in the same cycle.
- All other cycles: data_bus_data SHALL be high-Z.
- Unmapped offsets, and CMP slots with c >= CHANNELS, SHALL read 0.
- Register bits above WIDTH (COUNT, RELOAD, CMP) SHALL read 0.
REQ-014 Write with hit SHALL take effect at the next rising clk edge.
- Data SHALL be truncated to register width.
- Writes to unmapped offsets SHALL be ignored.
REQ-015 Prescaler: an internal 8-bit count p SHALL increment each cycle while EN=1.
- When p == PRESCALE: p SHALL go to 0 and one tick SHALL be issued.
- Ticks therefore occur every PRESCALE+1 cycles; PRESCALE=0 gives one tick per cycle.
REQ-016 On a tick with COUNT != RELOAD, COUNT SHALL increment by 1.
REQ-017 On a tick with COUNT == RELOAD:
- COUNT SHALL go to 0 and STATUS[8] SHALL be set.
- If ONESHOT=1, EN SHALL clear in the same edge.
REQ-018 On a tick whose next COUNT equals CMP[c], STATUS[c] SHALL be set.
REQ-019 comparator_out[c] SHALL be registered and equal (COUNT < CMP[c]) after each edge.
- CMP[c]=0 SHALL hold the output low.
- CMP[c] > RELOAD SHALL hold the output high.
REQ-020 While EN=0: COUNT and p SHALL hold, and no flags SHALL be set.
REQ-021 A bus write to COUNT SHALL override the tick update in the same edge and SHALL reset p to 0.
REQ-022 A W1C write and a hardware set of the same STATUS bit in the same edge: the set SHALL win.
REQ-023 A write to CTRL setting EN=1 SHALL reset p to 0; the first tick occurs PRESCALE+1 cycles later.
REQ-024 timer_irq SHALL be registered and equal |(STATUS & IRQEN) one edge after any STATUS or IRQEN change.

Reset
REQ-025 While reset=0, independent of clk: CTRL, COUNT, STATUS, IRQEN and p SHALL be 0, RELOAD SHALL be all ones, and every CMP SHALL be 0.
REQ-026 While reset=0: timer_irq SHALL be 0, comparator_out SHALL be 0, and data_bus_data SHALL be high-Z.
REQ-027 Reset asserted mid-count SHALL abort immediately; after release the block SHALL stay idle until EN is written.

Verification
REQ-028 Free-run: RELOAD=4, PRESCALE=0, EN=1 -> COUNT sequence 1,2,3,4,0,1; STATUS[8] set on the 4->0 edge.
REQ-029 Prescale/PWM: PRESCALE=2, RELOAD=9, CMP[0]=3, EN=1 -> each COUNT value lasts 3 cycles; comparator_out[0] high for 9 of every 30 cycles; STATUS[0] set when COUNT becomes 3.
REQ-030 One-shot: ONESHOT=1, RELOAD=2, IRQEN[8]=1 -> COUNT 1,2,0 then holds at 0; EN reads 0; timer_irq rises one edge after STATUS[8].
REQ-031 Collision: write STATUS=0x100 in the same cycle the counter wraps -> STATUS[8] remains 1. Separately, write COUNT=7 during a tick -> COUNT reads 7.
REQ-032 Bus isolation: read at base_address+0x40 and at offset 0x3C with CHANNELS=4 -> the first leaves data_bus_data high-Z, the second reads 0.
REQ-033 Async reset: assert reset=0 between clock edges mid-count -> all outputs go to reset values without a clock edge; RELOAD reads 32'h0000FFFF for WIDTH=16.

Source files
------------

// File: rtl/multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : multi_timer
// Brief    : Prescaled up-counter with reload, per-channel compare/PWM outputs
//            and a masked level interrupt, behind a 64-byte bus register window.
// Revision : 1.0
// ============================================================================
module multi_timer #(
  parameter logic [31:0] base_address = 32'h4100,
  parameter int          CHANNELS     = 4,
  parameter int          WIDTH        = 16
) (
  input  logic                clk,
  input  logic                reset,
  inout  wire  [31:0]         data_bus_data,
  input  logic [31:0]         data_bus_addr,
  input  logic [1:0]          data_bus_mode,
  output logic                timer_irq,
  output logic [CHANNELS-1:0] comparator_out
);

  localparam logic [1:0] c_mode_read   = 2'b01;
  localparam logic [1:0] c_mode_write  = 2'b10;
  localparam logic [5:0] c_off_ctrl    = 6'h00;
  localparam logic [5:0] c_off_count   = 6'h04;
  localparam logic [5:0] c_off_reload  = 6'h08;
  localparam logic [5:0] c_off_status  = 6'h0C;
  localparam logic [5:0] c_off_irqen   = 6'h10;
  localparam logic [8:0] c_status_mask = {1'b1, 8'((1 << CHANNELS) - 1)};

  logic             r_en;
  logic             r_oneshot;
  logic [7:0]       r_prescale;
  logic [7:0]       r_p;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] r_cmp [CHANNELS];
  logic [8:0]       r_status;
  logic [8:0]       r_irqen;
  logic             r_irq;
  logic [CHANNELS-1:0] r_cmp_out;

  logic             w_hit;
  logic             w_rd;
  logic             w_wr;
  logic [5:0]       w_off;
  logic [31:0]      w_wdata;
  logic [31:0]      w_rdata;
  logic             w_wr_ctrl;
  logic             w_wr_count;
  logic             w_wr_reload;
  logic             w_wr_status;
  logic             w_wr_irqen;
  logic [CHANNELS-1:0] w_wr_cmp;
  logic             w_tick;
  logic             w_wrap;
  logic [WIDTH-1:0] w_count_tick;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_cmp_nxt [CHANNELS];
  logic [8:0]       w_status_set;
  logic [8:0]       w_status_clr;
  logic             w_unused;

  assign w_hit   = (data_bus_addr[31:6] == base_address[31:6]);
  assign w_off   = data_bus_addr[5:0];
  assign w_rd    = reset && w_hit && (data_bus_mode == c_mode_read);
  assign w_wr    = w_hit && (data_bus_mode == c_mode_write);
  assign w_wdata = data_bus_data;
  assign w_unused = ^w_wdata;

  assign data_bus_data = w_rd ? w_rdata : 32'bz;

  assign w_wr_ctrl   = w_wr && (w_off == c_off_ctrl);
  assign w_wr_count  = w_wr && (w_off == c_off_count);
  assign w_wr_reload = w_wr && (w_off == c_off_reload);
  assign w_wr_status = w_wr && (w_off == c_off_status);
  assign w_wr_irqen  = w_wr && (w_off == c_off_irqen);

  assign w_tick = r_en && (r_p == r_prescale);
  assign w_wrap = w_tick && (r_count == r_reload);

  always_comb begin
    w_count_tick = r_count;
    if (w_tick) w_count_tick = w_wrap ? '0 : r_count + 1'b1;
  end

  // A bus write to COUNT takes precedence over the tick update.
  assign w_count_nxt  = w_wr_count ? w_wdata[WIDTH-1:0] : w_count_tick;
  assign w_status_clr = w_wr_status ? w_wdata[8:0] : 9'h000;

  always_comb begin
    w_wr_cmp     = '0;
    w_status_set = '0;
    w_status_set[8] = w_wrap;
    for (int c = 0; c < CHANNELS; c++) begin
      w_wr_cmp[c]     = w_wr && (w_off == 6'(32 + 4 * c));
      w_cmp_nxt[c]    = w_wr_cmp[c] ? w_wdata[WIDTH-1:0] : r_cmp[c];
      w_status_set[c] = w_tick && (w_count_tick == r_cmp[c]);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      c_off_ctrl:   w_rdata = {16'h0000, r_prescale, 6'b000000, r_oneshot, r_en};
      c_off_count:  w_rdata = 32'(r_count);
      c_off_reload: w_rdata = 32'(r_reload);
      c_off_status: w_rdata = {23'h0, r_status};
      c_off_irqen:  w_rdata = {23'h0, r_irqen};
      default:      w_rdata = '0;
    endcase
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_off == 6'(32 + 4 * c)) w_rdata = 32'(r_cmp[c]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en       <= 1'b0;
      r_oneshot  <= 1'b0;
      r_prescale <= '0;
      r_p        <= '0;
      r_count    <= '0;
      r_reload   <= '1;
      r_status   <= '0;
      r_irqen    <= '0;
      r_irq      <= 1'b0;
      r_cmp_out  <= '0;
      for (int c = 0; c < CHANNELS; c++) r_cmp[c] <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_en       <= w_wdata[0];
        r_oneshot  <= w_wdata[1];
        r_prescale <= w_wdata[15:8];
      end else if (w_wrap && r_oneshot) begin
        r_en <= 1'b0;
      end

      // Enabling or reloading COUNT restarts the prescaler phase.
      if (w_wr_count || (w_wr_ctrl && w_wdata[0])) r_p <= '0;
      else if (w_tick)                             r_p <= '0;
      else if (r_en)                               r_p <= r_p + 8'd1;

      r_count <= w_count_nxt;
      if (w_wr_reload) r_reload <= w_wdata[WIDTH-1:0];
      if (w_wr_irqen)  r_irqen  <= w_wdata[8:0] & c_status_mask;

      // Hardware set wins over a simultaneous write-1-to-clear.
      r_status <= ((r_status & ~w_status_clr) | w_status_set) & c_status_mask;
      r_irq    <= |(r_status & r_irqen);

      for (int c = 0; c < CHANNELS; c++) begin
        r_cmp[c]     <= w_cmp_nxt[c];
        r_cmp_out[c] <= (w_count_nxt < w_cmp_nxt[c]);
      end
    end
  end

  assign timer_irq      = r_irq;
  assign comparator_out = r_cmp_out;

endmodule
`default_nettype wire

// File: tb/tb_multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_timer
// Brief    : Scoreboard bench for multi_timer: counting, prescale/PWM,
//            one-shot, collisions, bus decode and asynchronous reset.
// Revision : 1.0
// ============================================================================
module tb_multi_timer;

  localparam logic [31:0] c_base   = 32'h4100;
  localparam int          c_ch     = 4;
  localparam logic [31:0] c_ctrl   = c_base + 32'h00;
  localparam logic [31:0] c_count  = c_base + 32'h04;
  localparam logic [31:0] c_reload = c_base + 32'h08;
  localparam logic [31:0] c_status = c_base + 32'h0C;
  localparam logic [31:0] c_irqen  = c_base + 32'h10;
  localparam logic [31:0] c_cmp0   = c_base + 32'h20;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  tri1  [31:0]     data_bus_data;
  logic [31:0]     data_bus_addr = '0;
  logic [1:0]      data_bus_mode = 2'b00;
  logic            timer_irq;
  logic [c_ch-1:0] comparator_out;

  logic            r_drv = 1'b0;
  logic [31:0]     r_drv_data = '0;
  assign data_bus_data = r_drv ? r_drv_data : 32'bz;

  int n_checks = 0;
  int n_pass   = 0;
  string       sb_tag [$];
  logic [31:0] sb_exp [$];

  always #5 clk = ~clk;

  multi_timer #(
    .base_address(c_base),
    .CHANNELS    (c_ch),
    .WIDTH       (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_bus_data (data_bus_data),
    .data_bus_addr (data_bus_addr),
    .data_bus_mode (data_bus_mode),
    .timer_irq     (timer_irq),
    .comparator_out(comparator_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    sb_tag.push_back(tag);
    sb_exp.push_back(v);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (sb_exp.size() == 0) begin
      check("sb_empty", 32'(sb_exp.size()), 32'd1);
    end else begin
      string       t;
      logic [31:0] e;
      t = sb_tag.pop_front();
      e = sb_exp.pop_front();
      check(t, obs, e);
    end
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] d);
    data_bus_addr = addr;
    data_bus_mode = 2'b01;
    #1;
    d = data_bus_data;
    data_bus_mode = 2'b00;
  endtask

  task automatic rd_sb(input logic [31:0] addr);
    logic [31:0] d;
    rd(addr, d);
    sb_pop(d);
  endtask

  // Write lands on the posedge following the next negedge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] d);
    @(negedge clk);
    data_bus_addr = addr;
    data_bus_mode = 2'b10;
    r_drv_data    = d;
    r_drv         = 1'b1;
    @(posedge clk);
    #1;
    data_bus_mode = 2'b00;
    r_drv         = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          hi;

    // Reset asserted before any clock edge
    #1 reset = 1'b0;
    #2;
    check("rst_irq", 32'(timer_irq), 32'd0);
    check("rst_pwm", 32'(comparator_out), 32'd0);
    rd(c_reload, d);
    check("rst_bus_z", d, 32'hFFFF_FFFF);
    @(negedge clk);
    reset = 1'b1;
    #1;
    expect_val("rst_ctrl",   32'h0);
    expect_val("rst_count",  32'h0);
    expect_val("rst_reload", 32'h0000_FFFF);
    expect_val("rst_status", 32'h0);
    expect_val("rst_irqen",  32'h0);
    expect_val("rst_cmp0",   32'h0);
    expect_val("rst_cmp3",   32'h0);
    rd_sb(c_ctrl); rd_sb(c_count); rd_sb(c_reload); rd_sb(c_status);
    rd_sb(c_irqen); rd_sb(c_cmp0); rd_sb(c_cmp0 + 32'h0C);

    // Free-run: RELOAD=4, PRESCALE=0
    wr(c_reload, 32'd4);
    wr(c_ctrl, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      expect_val("free_count", 32'(k % 5));
      expect_val("free_status", (k >= 5) ? 32'h10F : 32'h0);
    end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #2;
      rd_sb(c_count);
      rd_sb(c_status);
    end

    // Prescale / PWM: PRESCALE=2, RELOAD=9, CMP0=3
    do_reset();
    wr(c_reload, 32'd9);
    wr(c_cmp0, 32'd3);
    wr(c_ctrl, 32'h0201);
    #1;
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      expect_val("ps_count", 32'((k / 3) % 10));
      expect_val("ps_stat0", (k >= 9) ? 32'd1 : 32'd0);
      expect_val("ps_pwm0", (((k / 3) % 10) < 3) ? 32'd1 : 32'd0);
      rd_sb(c_count);
      rd(c_status, d);
      sb_pop(d & 32'h1);
      sb_pop(32'(comparator_out[0]));
      hi += int'(comparator_out[0]);
      @(posedge clk); #2;
    end
    check("ps_pwm_high_cycles", 32'(hi), 32'd9);

    // One-shot with overflow interrupt
    do_reset();
    wr(c_reload, 32'd2);
    wr(c_irqen, 32'h100);
    wr(c_ctrl, 32'h3);
    for (int k = 1; k <= 6; k++) begin
      expect_val("os_count", (k <= 2) ? 32'(k) : 32'd0);
      expect_val("os_irq", (k >= 4) ? 32'd1 : 32'd0);
    end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #2;
      rd_sb(c_count);
      sb_pop(32'(timer_irq));
    end
    expect_val("os_ctrl", 32'h2);
    expect_val("os_status", 32'h10F);
    rd_sb(c_ctrl);
    rd_sb(c_status);

    // Collisions: W1C vs wrap, COUNT write vs tick
    do_reset();
    wr(c_reload, 32'd4);
    wr(c_ctrl, 32'h1);
    repeat (4) @(posedge clk);
    wr(c_status, 32'h100);
    expect_val("col_set_wins", 32'h10F);
    rd_sb(c_status);
    wr(c_status, 32'h10F);
    expect_val("col_w1c", 32'h0);
    rd_sb(c_status);
    wr(c_count, 32'd7);
    expect_val("col_count_wr", 32'd7);
    rd_sb(c_count);
    @(posedge clk); #2;
    expect_val("col_count_next", 32'd8);
    rd_sb(c_count);

    // Bus decode and truncation
    do_reset();
    rd(c_base + 32'h40, d);
    check("iso_miss_z", d, 32'hFFFF_FFFF);
    expect_val("iso_cmp_slot_3c", 32'h0);
    expect_val("iso_unmapped_14", 32'h0);
    rd_sb(c_base + 32'h3C);
    rd_sb(c_base + 32'h14);
    wr(c_base + 32'h44, 32'h55);
    expect_val("iso_miss_write", 32'h0);
    rd_sb(c_count);
    wr(c_cmp0, 32'hABCD_1234);
    expect_val("iso_cmp_trunc", 32'h0000_1234);
    rd_sb(c_cmp0);

    // Asynchronous reset mid-count
    do_reset();
    wr(c_reload, 32'd3);
    wr(c_irqen, 32'h100);
    wr(c_cmp0, 32'd8);
    wr(c_ctrl, 32'h1);
    repeat (6) @(posedge clk);
    #2;
    check("ar_irq_before", 32'(timer_irq), 32'd1);
    check("ar_pwm_before", 32'(comparator_out), 32'h1);
    #1 reset = 1'b0;
    #1;
    check("ar_irq_async", 32'(timer_irq), 32'd0);
    check("ar_pwm_async", 32'(comparator_out), 32'd0);
    rd(c_reload, d);
    check("ar_bus_z", d, 32'hFFFF_FFFF);
    @(negedge clk);
    reset = 1'b1;
    #1;
    expect_val("ar_reload", 32'h0000_FFFF);
    expect_val("ar_count", 32'h0);
    expect_val("ar_ctrl", 32'h0);
    expect_val("ar_status", 32'h0);
    rd_sb(c_reload); rd_sb(c_count); rd_sb(c_ctrl); rd_sb(c_status);
    repeat (5) @(posedge clk);
    #2;
    expect_val("ar_idle_count", 32'h0);
    rd_sb(c_count);

    check("sb_drained", 32'(sb_exp.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
